// File: rtl/draw_apple_array.sv
// Grid overlay stage: draws up to N_APPLES cell-sized apples onto rgb_in, with 2-cycle latency on all pixel/timing outputs.
// Positions latch on the vsync rising edge. Define APPLE_SPRITE_EN for the stem/leaf sprite, otherwise flat squares are drawn.
module draw_apple_array #(
  parameter int N_APPLES = 4,
  parameter int XW       = 7,
  parameter int YW       = 6
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  logic [10:0]            vcount_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  input  logic [N_APPLES*XW-1:0] apple_x,
  input  logic [N_APPLES*YW-1:0] apple_y,
  input  logic [N_APPLES-1:0]    apple_valid,
  input  logic [9:0]             grid_size,
  output logic [10:0]            hcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic [10:0]            vcount_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out,
  output logic [N_APPLES-1:0]    apple_drawn
);
  localparam int SELW = (N_APPLES > 1) ? $clog2(N_APPLES) : 1;

  logic                   vsync_d_q;
  logic                   vs_rise;
  logic [N_APPLES*XW-1:0] sx_q;
  logic [N_APPLES*YW-1:0] sy_q;
  logic [N_APPLES-1:0]    sval_q;
  logic [9:0]             sgs_q;
  logic [16:0]            x0_q [N_APPLES];
  logic [16:0]            y0_q [N_APPLES];

  logic [16:0]            h_ext, v_ext, sgs_ext;
  logic                   hit_d, hit1_q;
  logic [SELW-1:0]        sel_d, sel1_q;
  logic [11:0]            rgb1_q;
  logic [10:0]            h1_q, v1_q;
  logic                   hs1_q, hb1_q, vs1_q, vb1_q;

  logic                   opaque;
  logic [11:0]            colour;
  logic [N_APPLES-1:0]    acc_q, acc_d;

  // Sampled even in reset, so a vsync already high at release is not a rise.
  always_ff @(posedge pclk) vsync_d_q <= vsync_in;
  assign vs_rise = vsync_in & ~vsync_d_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      sx_q   <= '0;
      sy_q   <= '0;
      sval_q <= '0;
      sgs_q  <= '0;
    end else if (vs_rise) begin
      sx_q   <= apple_x;
      sy_q   <= apple_y;
      sval_q <= apple_valid;
      sgs_q  <= grid_size;
    end
  end

  always_ff @(posedge pclk) begin
    for (int i = 0; i < N_APPLES; i++) begin
      if (rst) begin
        x0_q[i] <= '0;
        y0_q[i] <= '0;
      end else begin
        x0_q[i] <= 17'(sx_q[i*XW +: XW]) * 17'(sgs_q);
        y0_q[i] <= 17'(sy_q[i*YW +: YW]) * 17'(sgs_q);
      end
    end
  end

  assign h_ext   = 17'(hcount_in);
  assign v_ext   = 17'(vcount_in);
  assign sgs_ext = 17'(sgs_q);

`ifdef APPLE_SPRITE_EN
  logic [16:0] x0_sel, y0_sel;
  logic [9:0]  dx1_q, dy1_q;
  logic [9:0]  q_sz, c_sz, gs_m1;
  logic [10:0] cq_sz;
  assign q_sz  = sgs_q >> 2;
  assign c_sz  = sgs_q >> 1;
  assign cq_sz = {1'b0, c_sz} + {1'b0, q_sz};
  assign gs_m1 = sgs_q - 10'd1;
`endif

  // Descending scan so the lowest matching index is the one left selected.
  always_comb begin
    hit_d  = 1'b0;
    sel_d  = '0;
`ifdef APPLE_SPRITE_EN
    x0_sel = '0;
    y0_sel = '0;
`endif
    for (int i = N_APPLES - 1; i >= 0; i--) begin
      if (sval_q[i] && (sgs_q != 10'd0) && !hblnk_in && !vblnk_in &&
          (h_ext >= x0_q[i]) && (h_ext < x0_q[i] + sgs_ext) &&
          (v_ext >= y0_q[i]) && (v_ext < y0_q[i] + sgs_ext)) begin
        hit_d  = 1'b1;
        sel_d  = SELW'(i);
`ifdef APPLE_SPRITE_EN
        x0_sel = x0_q[i];
        y0_sel = y0_q[i];
`endif
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hit1_q <= 1'b0;
      sel1_q <= '0;
      rgb1_q <= '0;
      h1_q   <= '0;
      hs1_q  <= 1'b0;
      hb1_q  <= 1'b0;
      v1_q   <= '0;
      vs1_q  <= 1'b0;
      vb1_q  <= 1'b0;
`ifdef APPLE_SPRITE_EN
      dx1_q  <= '0;
      dy1_q  <= '0;
`endif
    end else begin
      hit1_q <= hit_d;
      sel1_q <= sel_d;
      rgb1_q <= rgb_in;
      h1_q   <= hcount_in;
      hs1_q  <= hsync_in;
      hb1_q  <= hblnk_in;
      v1_q   <= vcount_in;
      vs1_q  <= vsync_in;
      vb1_q  <= vblnk_in;
`ifdef APPLE_SPRITE_EN
      dx1_q  <= 10'(h_ext - x0_sel);
      dy1_q  <= 10'(v_ext - y0_sel);
`endif
    end
  end

  always_comb begin
    opaque = 1'b0;
    colour = 12'hb20;
`ifdef APPLE_SPRITE_EN
    if (hit1_q) begin
      if (dy1_q < q_sz) begin
        if (dx1_q == c_sz) begin
          opaque = 1'b1;
          colour = 12'h850;
        end else if ((dx1_q > c_sz) && ({1'b0, dx1_q} <= cq_sz)) begin
          opaque = 1'b1;
          colour = 12'h160;
        end
      end else if (!((dy1_q == gs_m1) && ((dx1_q == 10'd0) || (dx1_q == gs_m1)))) begin
        opaque = 1'b1;
      end
    end
`else
    opaque = hit1_q;
`endif
    acc_d = acc_q;
    for (int i = 0; i < N_APPLES; i++) begin
      if (opaque && (sel1_q == SELW'(i))) acc_d[i] = 1'b1;
    end
    if (vs_rise) acc_d = '0;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out  <= '0;
      hsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vcount_out  <= '0;
      vsync_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      rgb_out     <= '0;
      acc_q       <= '0;
      apple_drawn <= '0;
    end else begin
      hcount_out  <= h1_q;
      hsync_out   <= hs1_q;
      hblnk_out   <= hb1_q;
      vcount_out  <= v1_q;
      vsync_out   <= vs1_q;
      vblnk_out   <= vb1_q;
      rgb_out     <= opaque ? colour : rgb1_q;
      acc_q       <= acc_d;
      if (vs_rise) apple_drawn <= acc_q;
    end
  end
endmodule
